reg_file_seq: RTL and testbench

Multi-cycle operand sequencer for the CPU register file: owns reg_SA, reg_DA, RW, As and reg_Din.
- Per decoded instruction: fetches source and destination operands, substitutes constant-generator values, hands operands to the ALU, waits for its result, writes back.
- Sits between the decoder/control unit and the register file; one instruction in flight.

---
 rtl/reg_file_seq.sv | 206 ++++++++++++++++++++
 tb/tb_reg_file_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_seq.sv
// reg_file_seq: multi-cycle operand sequencer for the CPU register file.
// Fetches source/destination operands (with constant-generator substitution),
// starts the ALU, waits for its result with a timeout, and writes back.
// Optional build macro: REG_SEQ_PERF_EN adds perf_ops / perf_stall counters.
module reg_file_seq #(
    parameter int ALU_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op_fmt,
    input  logic [3:0]  src_reg,
    input  logic [3:0]  dst_reg,
    input  logic [1:0]  as_in,
    input  logic        wb_en,
    input  logic [15:0] Sout,
    input  logic [15:0] Dout,
    input  logic [15:0] alu_result,
    input  logic        alu_ready,
    output logic [3:0]  reg_SA,
    output logic [3:0]  reg_DA,
    output logic        RW,
    output logic [1:0]  As,
    output logic [15:0] reg_Din,
    output logic [15:0] src_op,
    output logic [15:0] dst_op,
    output logic        alu_go,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef REG_SEQ_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_SRC,
        S_FETCH_DST,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              err_n;
    logic [3:0]        src_q;
    logic [3:0]        dst_q;
    logic [1:0]        as_q;
    logic              wb_q;
    logic [TO_W-1:0]   cnt;
    logic [15:0]       src_val;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state decode; err_n flags an error-terminated sequence on entry to DONE
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op_fmt)
                        2'd0:    state_n = S_FETCH_SRC;
                        2'd1:    state_n = S_FETCH_DST;
                        2'd2:    state_n = S_DONE;
                        default: begin
                            state_n = S_DONE;
                            err_n   = 1'b1;
                        end
                    endcase
                end
            end
            S_FETCH_SRC: state_n = S_FETCH_DST;
            S_FETCH_DST: state_n = S_EXEC;
            S_EXEC: begin
                if (alu_ready) begin
                    state_n = (wb_q && (dst_q != 4'd3)) ? S_WB : S_DONE;
                end else if (cnt == TO_W'(ALU_TIMEOUT - 1)) begin
                    state_n = S_DONE;
                    err_n   = 1'b1;
                end
            end
            S_WB:    state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Constant-generator substitution for R2/R3 source reads
    always_comb begin
        src_val = Sout;
        if (src_q == 4'd2) begin
            case (as_q)
                2'b01:   src_val = 16'h0000;
                2'b10:   src_val = 16'h0004;
                2'b11:   src_val = 16'h0008;
                default: src_val = Sout;
            endcase
        end else if (src_q == 4'd3) begin
            case (as_q)
                2'b00:   src_val = 16'h0000;
                2'b01:   src_val = 16'h0001;
                2'b10:   src_val = 16'h0002;
                default: src_val = 16'hFFFF;
            endcase
        end
    end

    // Instruction field latch, captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
            dst_q <= '0;
            as_q  <= '0;
            wb_q  <= 1'b0;
        end else if (state == S_IDLE && start) begin
            src_q <= src_reg;
            dst_q <= dst_reg;
            as_q  <= as_in;
            wb_q  <= wb_en;
        end
    end

    // ALU timeout counter: counts stalled EXEC cycles, cleared outside EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != S_EXEC) begin
            cnt <= '0;
        end else if (!alu_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered outputs, loaded on the edge that enters the state they belong to
    // so that addresses/strobes are stable for the whole state cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_SA  <= '0;
            reg_DA  <= '0;
            RW      <= 1'b0;
            As      <= '0;
            reg_Din <= '0;
            src_op  <= '0;
            dst_op  <= '0;
            alu_go  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            RW     <= (state_n == S_WB);
            alu_go <= (state_n == S_EXEC) && (state != S_EXEC);
            done   <= (state_n == S_DONE);
            err    <= err_n;
            if (state == S_IDLE && start && op_fmt == 2'd0) begin
                reg_SA <= src_reg;
                As     <= as_in;
            end
            // Fields are latched on this same edge, so IDLE entry uses the live input
            if (state_n == S_FETCH_DST) begin
                reg_DA <= (state == S_IDLE) ? dst_reg : dst_q;
            end
            if (state_n == S_WB) begin
                reg_DA  <= dst_q;
                reg_Din <= alu_result;
            end
            if (state == S_FETCH_SRC) begin
                src_op <= src_val;
            end
            if (state == S_FETCH_DST) begin
                dst_op <= (dst_q == 4'd3) ? 16'h0000 : Dout;
            end
        end
    end

    // Busy in every state except IDLE
    always_comb begin
        busy = (state != S_IDLE);
    end

`ifdef REG_SEQ_PERF_EN
    // Saturating performance counters: error-free completions and ALU stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (state == S_DONE && !err && perf_ops != '1) begin
                perf_ops <= perf_ops + 1'b1;
            end
            if (state == S_EXEC && !alu_ready && perf_stall != '1) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_seq.sv
// Self-checking bench for reg_file_seq (default build, ALU_TIMEOUT=4).
module tb_reg_file_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op_fmt;
    logic [3:0]  src_reg;
    logic [3:0]  dst_reg;
    logic [1:0]  as_in;
    logic        wb_en;
    logic [15:0] Sout;
    logic [15:0] Dout;
    logic [15:0] alu_result;
    logic        alu_ready;
    logic [3:0]  reg_SA;
    logic [3:0]  reg_DA;
    logic        RW;
    logic [1:0]  As;
    logic [15:0] reg_Din;
    logic [15:0] src_op;
    logic [15:0] dst_op;
    logic        alu_go;
    logic        busy;
    logic        done;
    logic        err;

    int errors;
    int checks;

    reg_file_seq #(.ALU_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op_fmt(op_fmt),
        .src_reg(src_reg), .dst_reg(dst_reg), .as_in(as_in), .wb_en(wb_en),
        .Sout(Sout), .Dout(Dout), .alu_result(alu_result), .alu_ready(alu_ready),
        .reg_SA(reg_SA), .reg_DA(reg_DA), .RW(RW), .As(As), .reg_Din(reg_Din),
        .src_op(src_op), .dst_op(dst_op), .alu_go(alu_go), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [1:0]  am;
        logic        wb;
        logic [15:0] sout;
        logic [15:0] dout;
        logic [15:0] res;
        int          dly;
        logic        mid;
        logic [15:0] exp_src;
        logic [15:0] exp_dst;
        logic        chk_src;
        logic        chk_dst;
        int          exp_rw;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [62:0] out_pack();
        return {reg_SA, reg_DA, RW, As, reg_Din, src_op, dst_op, alu_go, busy, done, err};
    endfunction

    // Apply one instruction, play the ALU, and compare the observed sequence
    task automatic run_vec(input vec_t v, input int idx);
        int exec_k;
        int done_c;
        int rw_c;
        int rw_cnt;
        int go_cnt;
        logic        err_s;
        logic [3:0]  da_s;
        logic [15:0] din_s;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk);
        #1;
        op_fmt = v.fmt; src_reg = v.src; dst_reg = v.dst; as_in = v.am; wb_en = v.wb;
        Sout = v.sout; Dout = v.dout; alu_result = v.res; alu_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_fmt = ~v.fmt; src_reg = ~v.src; dst_reg = ~v.dst; as_in = ~v.am; wb_en = ~v.wb;
        exec_k = -1; done_c = 0; rw_c = 0; rw_cnt = 0; go_cnt = 0;
        err_s = 1'b0; da_s = '0; din_s = '0;
        for (int n = 1; n <= 20 && done_c == 0; n++) begin
            @(negedge clk);
            if (v.fmt == 2'd0 && n == 1) chk({tag, "_src_addr"}, {reg_SA, As}, {v.src, v.am});
            if ((v.fmt == 2'd0 && n == 2) || (v.fmt == 2'd1 && n == 1))
                chk({tag, "_dst_addr"}, reg_DA, v.dst);
            if (v.mid && n == 2) begin start = 1'b1; op_fmt = 2'd3; end
            if (v.mid && n == 3) start = 1'b0;
            if (alu_go) begin go_cnt++; exec_k = 0; end
            if (exec_k >= 0) begin alu_ready = (exec_k >= v.dly); exec_k++; end
            if (RW) begin rw_cnt++; rw_c = n; da_s = reg_DA; din_s = reg_Din; end
            if (done) begin done_c = n; err_s = err; end
        end
        alu_ready = 1'b0;
        chk({tag, "_done_cycle"}, done_c, v.exp_done);
        chk({tag, "_err"}, err_s, v.exp_err);
        chk({tag, "_rw_count"}, rw_cnt, v.exp_rw);
        chk({tag, "_alu_go_count"}, go_cnt, (v.fmt < 2'd2) ? 1 : 0);
        if (v.exp_rw != 0) begin
            chk({tag, "_wb_addr"}, da_s, v.dst);
            chk({tag, "_wb_data"}, din_s, v.res);
            chk({tag, "_wb_cycle"}, rw_c, done_c - 1);
        end
        if (v.chk_src) chk({tag, "_src_op"}, src_op, v.exp_src);
        if (v.chk_dst) chk({tag, "_dst_op"}, dst_op, v.exp_dst);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; start = 1'b0; op_fmt = '0; src_reg = '0; dst_reg = '0; as_in = '0;
        wb_en = 1'b0; Sout = '0; Dout = '0; alu_result = '0; alu_ready = 1'b0;

        //            fmt  src  dst  am  wb sout      dout      res       dly mid exp_src   exp_dst   cs cd rw done err
        vecs[0]  = '{2'd0, 4'd5, 4'd6, 2'd0, 1'b1, 16'h1234, 16'h0011, 16'h1245, 0, 1'b0, 16'h1234, 16'h0011, 1'b1, 1'b1, 1, 5, 1'b0};
        vecs[1]  = '{2'd0, 4'd3, 4'd4, 2'd3, 1'b1, 16'h5555, 16'h00A0, 16'h00AA, 1, 1'b0, 16'hFFFF, 16'h00A0, 1'b1, 1'b1, 1, 6, 1'b0};
        vecs[2]  = '{2'd0, 4'd2, 4'd7, 2'd2, 1'b0, 16'h9999, 16'h0001, 16'h0005, 0, 1'b0, 16'h0004, 16'h0001, 1'b1, 1'b1, 0, 4, 1'b0};
        vecs[3]  = '{2'd0, 4'd2, 4'd0, 2'd0, 1'b1, 16'hABCD, 16'h1111, 16'h2222, 0, 1'b0, 16'hABCD, 16'h1111, 1'b1, 1'b1, 1, 5, 1'b0};
        vecs[4]  = '{2'd1, 4'd9, 4'd3, 2'd1, 1'b1, 16'h7777, 16'h7777, 16'h3333, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 3, 1'b0};
        vecs[5]  = '{2'd0, 4'd1, 4'd5, 2'd1, 1'b1, 16'h4321, 16'h0002, 16'h0BAD, 99, 1'b1, 16'h4321, 16'h0002, 1'b1, 1'b1, 0, 7, 1'b1};
        vecs[6]  = '{2'd2, 4'd4, 4'd4, 2'd0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1, 1'b0};
        vecs[7]  = '{2'd3, 4'd4, 4'd4, 2'd0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1, 1'b1};
        vecs[8]  = '{2'd1, 4'd0, 4'd1, 2'd0, 1'b1, 16'h0000, 16'h00F0, 16'h0F0F, 2, 1'b0, 16'h0000, 16'h00F0, 1'b0, 1'b1, 1, 6, 1'b0};
        vecs[9]  = '{2'd0, 4'd3, 4'd2, 2'd2, 1'b1, 16'hFFFF, 16'h0F00, 16'h0001, 0, 1'b0, 16'h0002, 16'h0F00, 1'b1, 1'b1, 1, 5, 1'b0};
        vecs[10] = '{2'd0, 4'd2, 4'd3, 2'd1, 1'b1, 16'h8888, 16'h5555, 16'h4444, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, 4, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", out_pack(), '0);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
            // After the timeout run, the start pulsed while busy must not launch anything
            if (vecs[i].mid) begin
                int act;
                act = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (done || busy) act++;
                end
                chk("ignored_busy_start", act, 0);
            end
        end

        // Reset asserted in EXEC aborts the sequence
        begin
            logic found;
            int   act;
            @(posedge clk);
            #1;
            op_fmt = 2'd0; src_reg = 4'd5; dst_reg = 4'd6; as_in = 2'd0; wb_en = 1'b1;
            Sout = 16'h1234; Dout = 16'h0011; alu_result = 16'h1245; alu_ready = 1'b0;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            found = 1'b0;
            for (int n = 0; n < 10 && !found; n++) begin
                @(negedge clk);
                found = alu_go;
            end
            chk("rst_exec_reached", found, 1'b1);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_abort_outputs", out_pack(), '0);
            rst = 1'b0;
            act = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done || RW || busy) act++;
            end
            chk("rst_abort_quiet", act, 0);
        end
        run_vec(vecs[0], 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
